// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: captures the MEM-stage instruction into the WB register,
// selects the register-file write data (PC+4, CSR, extended load data, ALU) and
// counts retired instructions.
// Ports:
//   WB_CLK, WB_RST            clock, synchronous active-high reset
//   WB_STALL, WB_FLUSH        hold WB contents / replace capture with a bubble
//   MEM_*                     instruction fields presented by the MEM stage
//   WB_DOUT2                  raw memory word for the load currently in WB
//   RF_WA, RF_WD, RF_EN       register-file write port
//   WB_INSTRET                retired-instruction counter (CNT_W bits, wraps)
module mem_wb_stage #(
   parameter int unsigned CNT_W = 64
) (
   input  logic             WB_CLK,
   input  logic             WB_RST,
   input  logic             WB_STALL,
   input  logic             WB_FLUSH,
   input  logic             MEM_VALID,
   input  logic             MEM_REG_WRITE,
   input  logic [4:0]       MEM_RD,
   input  logic [1:0]       MEM_RF_SEL,
   input  logic [1:0]       MEM_SIZE,
   input  logic             MEM_UNSIGNED,
   input  logic [1:0]       MEM_ADDR_LO,
   input  logic [31:0]      MEM_ALU_RES,
   input  logic [31:0]      MEM_PC,
   input  logic [31:0]      MEM_CSR_RD,
   input  logic [31:0]      WB_DOUT2,
   output logic [4:0]       RF_WA,
   output logic [31:0]      RF_WD,
   output logic             RF_EN,
   output logic [CNT_W-1:0] WB_INSTRET
);

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] SEL_PC4  = 2'd0;
   localparam logic [1:0] SEL_CSR  = 2'd1;
   localparam logic [1:0] SEL_LOAD = 2'd2;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;

   typedef struct packed {
      logic            valid;
      logic            reg_write;
      logic [4:0]      rd;
      logic [1:0]      rf_sel;
      logic [1:0]      size;
      logic            is_unsigned;
      logic [1:0]      addr_lo;
      logic [XLEN-1:0] alu_res;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] csr_rd;
   } wb_t;

   wb_t             wb;
   wb_t             mem_in;
   logic            held;
   logic [XLEN-1:0] hold_word;
   logic [CNT_W-1:0] instret;

   logic [XLEN-1:0] load_word;
   logic [7:0]      load_byte;
   logic [15:0]     load_half;
   logic [XLEN-1:0] load_data;

   always_comb begin
      mem_in = '{valid:       MEM_VALID,
                 reg_write:   MEM_REG_WRITE,
                 rd:          MEM_RD,
                 rf_sel:      MEM_RF_SEL,
                 size:        MEM_SIZE,
                 is_unsigned: MEM_UNSIGNED,
                 addr_lo:     MEM_ADDR_LO,
                 alu_res:     MEM_ALU_RES,
                 pc:          MEM_PC,
                 csr_rd:      MEM_CSR_RD};
   end

   // WB register, load-data hold and retire counter; reset > flush > stall > advance
   always_ff @(posedge WB_CLK) begin
      if (WB_RST) begin
         wb        <= '0;
         held      <= 1'b0;
         hold_word <= '0;
         instret   <= '0;
      end else begin
         // the instruction in WB retires only when it leaves normally
         if (wb.valid && !WB_STALL && !WB_FLUSH) begin
            instret <= instret + CNT_W'(1);
         end
         if (WB_FLUSH) begin
            wb   <= '0;
            held <= 1'b0;
         end else if (WB_STALL) begin
            // memory word is only guaranteed on the first WB cycle of a load
            if (wb.valid && (wb.rf_sel == SEL_LOAD) && !held) begin
               held      <= 1'b1;
               hold_word <= WB_DOUT2;
            end
         end else begin
            wb   <= mem_in;
            held <= 1'b0;
         end
      end
   end

   // load alignment and extension
   always_comb begin
      load_word = held ? hold_word : WB_DOUT2;
      load_byte = load_word[{wb.addr_lo, 3'b000} +: 8];
      load_half = wb.addr_lo[1] ? load_word[31:16] : load_word[15:0];
      case (wb.size)
         SZ_BYTE: load_data = {{24{~wb.is_unsigned & load_byte[7]}}, load_byte};
         SZ_HALF: load_data = {{16{~wb.is_unsigned & load_half[15]}}, load_half};
         default: load_data = load_word;
      endcase
   end

   // writeback source select
   always_comb begin
      case (wb.rf_sel)
         SEL_PC4:  RF_WD = wb.pc + XLEN'(4);
         SEL_CSR:  RF_WD = wb.csr_rd;
         SEL_LOAD: RF_WD = load_data;
         default:  RF_WD = wb.alu_res;
      endcase
   end

   assign RF_WA      = wb.rd;
   assign RF_EN      = wb.valid & wb.reg_write & (wb.rd != 5'd0) & ~WB_STALL;
   assign WB_INSTRET = instret;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized
// traffic, checked by a scoreboard against a behavioural model.
module tb_mem_wb_stage;

   logic        clk;
   logic        rst, stall, flush;
   logic        m_valid_i, m_rw_i, m_uns_i;
   logic [4:0]  m_rd_i;
   logic [1:0]  m_sel_i, m_size_i, m_lo_i;
   logic [31:0] m_alu_i, m_pc_i, m_csr_i, dout2;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic        rf_en;
   logic [63:0] instret;

   mem_wb_stage #(.CNT_W(64)) dut (
      .WB_CLK(clk), .WB_RST(rst), .WB_STALL(stall), .WB_FLUSH(flush),
      .MEM_VALID(m_valid_i), .MEM_REG_WRITE(m_rw_i), .MEM_RD(m_rd_i),
      .MEM_RF_SEL(m_sel_i), .MEM_SIZE(m_size_i), .MEM_UNSIGNED(m_uns_i),
      .MEM_ADDR_LO(m_lo_i), .MEM_ALU_RES(m_alu_i), .MEM_PC(m_pc_i),
      .MEM_CSR_RD(m_csr_i), .WB_DOUT2(dout2),
      .RF_WA(rf_wa), .RF_WD(rf_wd), .RF_EN(rf_en), .WB_INSTRET(instret));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model of the instruction sitting in WB
   typedef struct {
      bit          valid, rw, uns;
      bit [4:0]    rd;
      bit [1:0]    sel, size, lo;
      bit [31:0]   alu, pc, csr;
   } instr_t;

   instr_t      cur;
   bit          captured;   // word for the stalled load has been saved
   bit [31:0]   saved_word;
   longint unsigned retired;

   typedef struct {
      bit          en, valid;
      bit [4:0]    wa;
      bit [31:0]   wd;
      bit [63:0]   cnt;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit [31:0] model_wd(input bit [31:0] mem_word);
      bit [31:0] w, b, h;
      w = mem_word;
      b = (w >> (8 * cur.lo)) & 32'hFF;
      h = cur.lo[1] ? (w >> 16) : (w & 32'hFFFF);
      case (cur.sel)
         2'd0: return cur.pc + 32'd4;
         2'd1: return cur.csr;
         2'd3: return cur.alu;
         default: begin
            if (cur.size == 2'd0) return (!cur.uns && b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
            if (cur.size == 2'd1) return (!cur.uns && h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            return w;
         end
      endcase
   endfunction

   task automatic push_exp();
      exp_t e;
      e.valid = cur.valid;
      e.en    = cur.valid && cur.rw && (cur.rd != 0) && !stall;
      e.wa    = cur.rd;
      e.wd    = model_wd(captured ? saved_word : dout2);
      e.cnt   = retired;
      sb.push_back(e);
   endtask

   task automatic model_edge();
      if (rst) begin
         cur = '{default: 0};
         captured = 0;
         retired  = 0;
      end else begin
         if (cur.valid && !stall && !flush) retired++;
         if (flush) begin
            cur = '{default: 0};
            captured = 0;
         end else if (stall) begin
            if (cur.valid && cur.sel == 2'd2 && !captured) begin
               captured   = 1;
               saved_word = dout2;
            end
         end else begin
            cur = '{valid: m_valid_i, rw: m_rw_i, uns: m_uns_i, rd: m_rd_i, sel: m_sel_i,
                    size: m_size_i, lo: m_lo_i, alu: m_alu_i, pc: m_pc_i, csr: m_csr_i};
            captured = 0;
         end
      end
   endtask

   // one clock: record expectation, let the monitor sample, advance model with DUT
   task automatic tick();
      push_exp();
      @(negedge clk);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // monitor: compares DUT outputs against queued expectations mid-cycle
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("rf_en", 64'(rf_en), 64'(e.en));
         chk("instret", instret, e.cnt);
         if (e.valid) begin
            chk("rf_wa", 64'(rf_wa), 64'(e.wa));
            chk("rf_wd", 64'(rf_wd), 64'(e.wd));
         end
      end
   end

   task automatic idle();
      rst = 0; stall = 0; flush = 0;
      m_valid_i = 0; m_rw_i = 0; m_rd_i = 0; m_sel_i = 0; m_size_i = 0;
      m_uns_i = 0; m_lo_i = 0; m_alu_i = 0; m_pc_i = 0; m_csr_i = 0;
   endtask

   task automatic instr(input bit [4:0] rd, input bit [1:0] sel, input bit [1:0] size,
                        input bit uns, input bit [1:0] lo, input bit [31:0] alu,
                        input bit [31:0] pc);
      idle();
      m_valid_i = 1; m_rw_i = 1; m_rd_i = rd; m_sel_i = sel; m_size_i = size;
      m_uns_i = uns; m_lo_i = lo; m_alu_i = alu; m_pc_i = pc; m_csr_i = 32'hC5C5_0001;
   endtask

   typedef struct { bit [1:0] size; bit uns; bit [1:0] lo; bit [31:0] res; } ld_t;
   ld_t loads[5] = '{'{2'd0, 1'b0, 2'd1, 32'h0000007F},
                     '{2'd0, 1'b0, 2'd2, 32'hFFFFFFFF},
                     '{2'd0, 1'b1, 2'd3, 32'h00000080},
                     '{2'd1, 1'b0, 2'd2, 32'hFFFF80FF},
                     '{2'd1, 1'b1, 2'd0, 32'h00007F01}};

   initial begin
      cur = '{default: 0};
      captured = 0; saved_word = 0; retired = 0;
      idle();
      dout2 = 0;
      rst = 1;
      @(posedge clk); model_edge(); #1;
      tick();
      idle();
      #1;
      chk("reset_en", 64'(rf_en), 64'd0);
      chk("reset_wa", 64'(rf_wa), 64'd0);
      chk("reset_wd", 64'(rf_wd), 64'd4);
      chk("reset_cnt", instret, 64'd0);

      // ALU write
      instr(5'd5, 2'd3, 2'd2, 0, 0, 32'h12345678, 32'h100);
      tick(); idle(); #1;
      chk("alu_en", 64'(rf_en), 64'd1);
      chk("alu_wa", 64'(rf_wa), 64'd5);
      chk("alu_wd", 64'(rf_wd), 64'h12345678);
      tick();
      chk("alu_cnt", instret, 64'd1);

      // load extraction
      dout2 = 32'h80FF7F01;
      foreach (loads[i]) begin
         instr(5'd3, 2'd2, loads[i].size, loads[i].uns, loads[i].lo, 0, 32'h200);
         tick(); idle(); #1;
         chk($sformatf("load%0d_wd", i), 64'(rf_wd), 64'(loads[i].res));
      end
      tick();
      chk("load_cnt", instret, 64'd6);

      // x0 write, then PC wrap
      instr(5'd0, 2'd3, 2'd2, 0, 0, 32'hAAAA5555, 32'h300);
      tick(); idle(); #1;
      chk("x0_en", 64'(rf_en), 64'd0);
      instr(5'd1, 2'd0, 2'd2, 0, 0, 0, 32'hFFFFFFFC);
      tick(); idle(); #1;
      chk("jal_wd", 64'(rf_wd), 64'd0);
      chk("x0_cnt", instret, 64'd7);
      tick();
      chk("jal_cnt", instret, 64'd8);

      // stalled load keeps the word seen on its first WB cycle
      instr(5'd9, 2'd2, 2'd2, 0, 0, 0, 32'h400);
      tick();
      idle(); stall = 1; dout2 = 32'hDEADBEEF; #1;
      chk("stall_en0", 64'(rf_en), 64'd0);
      tick();
      dout2 = 0; #1;
      chk("stall_en1", 64'(rf_en), 64'd0);
      tick();
      tick();
      stall = 0; #1;
      chk("unstall_en", 64'(rf_en), 64'd1);
      chk("unstall_wd", 64'(rf_wd), 64'hDEADBEEF);
      chk("stall_cnt", instret, 64'd8);
      tick();
      chk("stall_cnt1", instret, 64'd9);

      // stall + flush on the same edge
      instr(5'd7, 2'd3, 2'd2, 0, 0, 32'h77, 32'h500);
      tick();
      idle(); stall = 1; flush = 1;
      tick();
      idle(); #1;
      chk("flush_en", 64'(rf_en), 64'd0);
      chk("flush_cnt", instret, 64'd9);

      // reset during a stalled load
      instr(5'd4, 2'd2, 2'd2, 0, 0, 0, 32'h600);
      dout2 = 32'h13579BDF;
      tick();
      idle(); stall = 1;
      tick();
      rst = 1; stall = 1;
      tick();
      idle(); #1;
      chk("rststall_en", 64'(rf_en), 64'd0);
      chk("rststall_cnt", instret, 64'd0);
      chk("rststall_wd", 64'(rf_wd), 64'd4);
      // a following unstalled load must use live data, not a stale hold
      instr(5'd4, 2'd2, 2'd2, 0, 0, 0, 32'h700);
      tick();
      idle(); dout2 = 32'h2468ACE0; #1;
      chk("post_rst_wd", 64'(rf_wd), 64'h2468ACE0);
      tick();

      // randomized traffic
      for (int n = 0; n < 2000; n++) begin
         rst       = ($urandom_range(0, 99) < 2);
         flush     = ($urandom_range(0, 99) < 6);
         stall     = ($urandom_range(0, 99) < 25);
         m_valid_i = ($urandom_range(0, 99) < 80);
         m_rw_i    = ($urandom_range(0, 99) < 85);
         m_rd_i    = 5'($urandom_range(0, 31));
         m_sel_i   = 2'($urandom_range(0, 3));
         m_size_i  = 2'($urandom_range(0, 3));
         m_uns_i   = 1'($urandom_range(0, 1));
         m_lo_i    = 2'($urandom_range(0, 3));
         m_alu_i   = $urandom;
         m_pc_i    = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
         m_csr_i   = $urandom;
         dout2     = $urandom;
         tick();
      end
      idle();
      tick();
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: MEM_WB_STAGE

Interface
REQ-001 SHALL have parameter: CNT_W, 64, width of retired-instruction counter.
REQ-002 SHALL have port: WB_CLK  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: WB_RST  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: WB_STALL  in  1  hold current WB instruction.
REQ-005 SHALL have port: WB_FLUSH  in  1  replace captured instruction with bubble.
REQ-006 SHALL have port: MEM_VALID  in  1  MEM stage holds a real instruction.
REQ-007 SHALL have port: MEM_REG_WRITE  in  1  instruction writes rd.
REQ-008 SHALL have port: MEM_RD  in  5  destination register.
REQ-009 SHALL have port: MEM_RF_SEL  in  2  writeback source: 0 PC+4, 1 CSR, 2 load data, 3 ALU.
REQ-010 SHALL have port: MEM_SIZE  in  2  load size: 0 byte, 1 half, 2/3 word.
REQ-011 SHALL have port: MEM_UNSIGNED  in  1  zero-extend load (funct3[2]).
REQ-012 SHALL have port: MEM_ADDR_LO  in  2  load address bits [1:0].
REQ-013 SHALL have ports: MEM_ALU_RES, MEM_PC, MEM_CSR_RD  in  32 each  candidate results / instruction PC.
REQ-014 SHALL have port: WB_DOUT2  in  32  raw memory word, valid in the cycle the load occupies WB.
REQ-015 SHALL have ports: RF_WA  out  5; RF_WD  out  32; RF_EN  out  1  register-file write port (file writes on falling edge).
REQ-016 SHALL have port: WB_INSTRET  out  CNT_W  retired-instruction count.

Function
REQ-017 SHALL hold a WB register (valid, reg_write, rd, rf_sel, size, unsigned, addr_lo, alu_res, pc, csr_rd) loaded from MEM_* on each rising edge when not stalled.
REQ-018 SHALL apply per-edge priority: WB_RST > WB_FLUSH > WB_STALL > advance.
REQ-019 Flush SHALL load a bubble (valid=0, reg_write=0); flush overrides a simultaneous stall.
REQ-020 Stall SHALL keep every WB register field unchanged.
REQ-021 Latency SHALL be one cycle: instruction captured at edge N drives RF_* during cycle N..N+1.
REQ-022 RF_EN SHALL equal valid & reg_write & (rd != 0) & !WB_STALL; write to x0 never enabled.
REQ-023 RF_WA SHALL equal WB rd; RF_WD SHALL be selected combinationally by rf_sel.
REQ-024 rf_sel 0 SHALL give pc + 4 modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-025 Load byte SHALL select WB_DOUT2 byte addr_lo (0 = bits 7:0), sign- or zero-extended per unsigned.
REQ-026 Load half SHALL select bits 15:0 if addr_lo[1]=0 else 31:16; addr_lo[0] ignored; extended per unsigned.
REQ-027 Load word SHALL pass the 32-bit word unchanged; unsigned ignored.
REQ-028 Load data hold: on the first stalled cycle of a valid load, WB_DOUT2 SHALL be latched into a hold register with held=1; while held=1 the hold register SHALL replace WB_DOUT2.
REQ-029 held SHALL clear on any advance, flush, or reset.
REQ-030 WB_INSTRET SHALL increment by 1 on each rising edge where valid=1 and WB_STALL=0 (reg_write irrelevant), wrapping at 2^CNT_W.
REQ-031 Bubbles, stalled cycles, and flushes SHALL never increment WB_INSTRET.

Reset
REQ-032 On WB_RST at a rising edge: WB register cleared (valid=0, all fields 0), held=0, WB_INSTRET=0.
REQ-033 After reset, RF_EN=0, RF_WA=0, RF_WD=4 (pc 0 + 4, rf_sel 0) until first advance.
REQ-034 Reset mid-stall or mid-load SHALL discard the instruction with no register-file write.

Verification
REQ-035 ALU write: MEM_VALID=1, REG_WRITE=1, RD=5, RF_SEL=3, ALU_RES=0x12345678 -> next cycle RF_EN=1, RF_WA=5, RF_WD=0x12345678, INSTRET 0->1.
REQ-036 Loads with WB_DOUT2=0x80FF7F01: LB addr_lo=1 -> 0x0000007F; LB addr_lo=2 -> 0xFFFFFFFF; LBU addr_lo=3 -> 0x00000080; LH addr_lo=2 -> 0xFFFF80FF; LHU addr_lo=0 -> 0x00007F01.
REQ-037 x0 and PC wrap: RD=0 ALU write -> RF_EN=0, INSTRET still increments; JAL PC=0xFFFFFFFC RD=1 RF_SEL=0 -> RF_WD=0x00000000.
REQ-038 Stalled load: LW DOUT2=0xDEADBEEF, stall 3 cycles while DOUT2 changes to 0 -> RF_EN=0 during stall; first unstalled cycle RF_EN=1, RF_WD=0xDEADBEEF; INSTRET +1 once.
REQ-039 Stall+flush same edge: WB_STALL=1, WB_FLUSH=1 with valid write in WB -> next cycle bubble, RF_EN=0, INSTRET unchanged.
REQ-040 Reset mid-stall: valid load stalled, WB_RST=1 one edge -> RF_EN=0, held=0, WB_INSTRET=0, RF_WD=4.
